// File: rtl/common_pkg.sv
// common: datapath word and architectural register address types shared across the core.
package common;
    typedef logic [31:0] word_t;
    typedef logic [4:0]  creg_addr_t;
endpackage

// File: rtl/pipes_pkg.sv
// pipes: payload types passed between pipeline stages.
package pipes;
    import common::*;
    typedef struct packed {
        creg_addr_t addr;
        word_t      data;
    } wb_entry_t;
    // x0 is never written, so it never contributes a pending bit
    function automatic logic [31:0] reg_mask(input creg_addr_t a);
        return (a == '0) ? 32'd0 : (32'd1 << a);
    endfunction
endpackage

// File: rtl/wb_fifo2.sv
// wb_fifo2: writeback FIFO with dual push (e0 then e1) and single pop.
module wb_fifo2 import common::*; import pipes::*; #(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  push_n_i,
    input  wb_entry_t   e0_i,
    input  wb_entry_t   e1_i,
    input  logic        pop_i,
    output logic [CW-1:0] count_o,
    output wb_entry_t   head_o,
    output creg_addr_t  addr_o [DEPTH],
    output logic [DEPTH-1:0] valid_o
);
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d, off;
    logic [CW-1:0] count_q, count_d;
    wb_entry_t     mem_q [DEPTH];
    always_comb begin
        rd_d    = rd_q + PW'(pop_i);
        wr_d    = wr_q + PW'(push_n_i);
        count_d = count_q + CW'(push_n_i) - CW'(pop_i);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push_n_i != 2'd0) mem_q[wr_q] <= e0_i;
        if (push_n_i == 2'd2) mem_q[wr_q + PW'(1)] <= e1_i;
    end
    // an entry is live when its distance from the read pointer is below count
    always_comb begin
        off     = '0;
        valid_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off        = PW'(i) - rd_q;
            valid_o[i] = {1'b0, off} < count_q;
            addr_o[i]  = mem_q[i].addr;
        end
    end
    assign count_o = count_q;
    assign head_o  = mem_q[rd_q];
endmodule

// File: rtl/wb_queue.sv
// wb_queue: merges ALU (A) and MEM (B) results into one register-file write port.
// Define WB_BYPASS_EN to let the first result write in the same cycle when the queue is empty.
module wb_queue import common::*; import pipes::*; #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    output logic        a_ready,
    input  creg_addr_t  a_addr,
    input  word_t       a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  creg_addr_t  b_addr,
    input  word_t       b_data,
    output logic        wen,
    output creg_addr_t  wa,
    output word_t       wd,
    output logic [31:0] pending
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [CW-1:0]    count;
    wb_entry_t        head, a_ent, b_ent, first, e0, wb_out;
    creg_addr_t       addrs [DEPTH];
    logic [DEPTH-1:0] valid;
    logic             a_push, b_push, bypass, pop;
    logic [1:0]       push_n;
    always_comb begin
        b_ready = count < CW'(DEPTH);
        a_ready = b_valid ? count < CW'(DEPTH - 1) : b_ready;
        a_ent   = '{addr: a_addr, data: a_data};
        b_ent   = '{addr: b_addr, data: b_data};
        a_push  = a_valid && a_ready && a_addr != '0;
        b_push  = b_valid && b_ready && b_addr != '0;
        first   = b_push ? b_ent : a_ent;
`ifdef WB_BYPASS_EN
        bypass  = count == '0 && (a_push || b_push);
`else
        bypass  = 1'b0;
`endif
        push_n  = 2'(a_push) + 2'(b_push) - 2'(bypass);
        e0      = (b_push && !bypass) ? b_ent : a_ent;
        pop     = count != '0;
        wen     = pop || bypass;
        wb_out  = pop ? head : bypass ? first : '0;
        wa      = wb_out.addr;
        wd      = wb_out.data;
        pending = '0;
        for (int i = 0; i < DEPTH; i++)
            pending = pending | (valid[i] ? reg_mask(addrs[i]) : 32'd0);
    end
    wb_fifo2 #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_n_i (push_n),
        .e0_i     (e0),
        .e1_i     (a_ent),
        .pop_i    (pop),
        .count_o  (count),
        .head_o   (head),
        .addr_o   (addrs),
        .valid_o  (valid)
    );
endmodule
